// File: rtl/whack_cmd_pkg.sv
// Shared constants and types for the whack-a-mole PC-to-FPGA command link:
// packet bytes, opcodes, ACK/NAK codes, decoder FSM states and packet validation.
package whack_cmd_pkg;

    localparam logic [7:0] HDR_BYTE  = 8'hA5;
    localparam logic [7:0] OPC_START = 8'h01;
    localparam logic [7:0] OPC_HIT   = 8'h02;
    localparam logic [7:0] OPC_RESET = 8'h03;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;
    localparam int         MOLE_CNT  = 5;

    typedef enum logic [1:0] {
        S_HDR = 2'd0,
        S_OPC = 2'd1,
        S_ARG = 2'd2,
        S_CHK = 2'd3
    } state_t;

    // A packet is accepted only if the checksum matches and the argument
    // is legal for a known opcode.
    function automatic logic pkt_ok(
        input logic [7:0] opc,
        input logic [7:0] arg,
        input logic [7:0] chk
    );
        logic arg_ok;
        case (opc)
            OPC_START: arg_ok = (arg == 8'h00);
            OPC_HIT:   arg_ok = (arg[7:5] == 3'b000);
            OPC_RESET: arg_ok = (arg == 8'h00);
            default:   arg_ok = 1'b0;
        endcase
        return arg_ok && (chk == (opc ^ arg));
    endfunction

endpackage

// File: rtl/byte_timeout_timer.sv
// Inter-byte silence timer: counts while run is high, cleared by clear.
// Ports: clock, reset (async, active-high), clear, run -> expired (combinational).
module byte_timeout_timer #(
    parameter int TIMEOUT_CLKS = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CLKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // A byte arriving in the expiry cycle suppresses the timeout.
    assign expired = run & ~clear & (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || !run || expired) cnt_d = '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Frames 4-byte command packets (A5 OPC ARG CHK) from uart_rx into one-cycle
// start / hit / game-reset pulses, with error pulse and saturating error count.
// Ports: clock, reset, rx_data, rx_ready, game_active -> start_pulse, hit_mask,
// game_reset_pulse, cmd_error, error_count, busy.
// Optional UART_CMD_ACK_EN: adds ack_valid/ack_data outputs and ack_ready input.
module uart_cmd_decoder
    import whack_cmd_pkg::*;
#(
    parameter int TIMEOUT_CLKS = 1_000_000,
    parameter int ERR_CNT_W    = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [7:0]           rx_data,
    input  logic                 rx_ready,
    input  logic                 game_active,
`ifdef UART_CMD_ACK_EN
    output logic                 ack_valid,
    output logic [7:0]           ack_data,
    input  logic                 ack_ready,
`endif
    output logic                 start_pulse,
    output logic [MOLE_CNT-1:0]  hit_mask,
    output logic                 game_reset_pulse,
    output logic                 cmd_error,
    output logic [ERR_CNT_W-1:0] error_count,
    output logic                 busy
);

    state_t                state_q, state_d;
    logic [7:0]            opc_q, opc_d;
    logic [7:0]            arg_q, arg_d;
    logic                  start_q, start_d;
    logic [MOLE_CNT-1:0]   hit_q, hit_d;
    logic                  grst_q, grst_d;
    logic                  err_q, err_d;
    logic [ERR_CNT_W-1:0]  ecnt_q, ecnt_d;
    logic                  done_d;
    logic                  accept_d;
    logic                  expired;

    assign busy = (state_q != S_HDR);

    byte_timeout_timer #(
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (rx_ready),
        .run    (busy),
        .expired(expired)
    );

    always_comb begin
        state_d  = state_q;
        opc_d    = opc_q;
        arg_d    = arg_q;
        start_d  = 1'b0;
        hit_d    = '0;
        grst_d   = 1'b0;
        err_d    = 1'b0;
        done_d   = 1'b0;
        accept_d = 1'b0;
        if (rx_ready) begin
            unique case (state_q)
                S_HDR: if (rx_data == HDR_BYTE) state_d = S_OPC;
                S_OPC: begin
                    opc_d   = rx_data;
                    state_d = S_ARG;
                end
                S_ARG: begin
                    arg_d   = rx_data;
                    state_d = S_CHK;
                end
                S_CHK: begin
                    state_d  = S_HDR;
                    done_d   = 1'b1;
                    accept_d = pkt_ok(opc_q, arg_q, rx_data);
                    if (!accept_d) begin
                        err_d = 1'b1;
                    end else begin
                        case (opc_q)
                            OPC_START: start_d = 1'b1;
                            OPC_RESET: grst_d  = 1'b1;
                            default:   hit_d   = game_active ? arg_q[MOLE_CNT-1:0] : '0;
                        endcase
                    end
                end
            endcase
        end else if (expired) begin
            state_d = S_HDR;
            err_d   = 1'b1;
        end
    end

    always_comb begin
        ecnt_d = ecnt_q;
        if (err_d && (ecnt_q != '1)) ecnt_d = ecnt_q + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_HDR;
            opc_q   <= '0;
            arg_q   <= '0;
            start_q <= 1'b0;
            hit_q   <= '0;
            grst_q  <= 1'b0;
            err_q   <= 1'b0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            arg_q   <= arg_d;
            start_q <= start_d;
            hit_q   <= hit_d;
            grst_q  <= grst_d;
            err_q   <= err_d;
            ecnt_q  <= ecnt_d;
        end
    end

    assign start_pulse      = start_q;
    assign hit_mask         = hit_q;
    assign game_reset_pulse = grst_q;
    assign cmd_error        = err_q;
    assign error_count      = ecnt_q;

`ifdef UART_CMD_ACK_EN
    logic       ackv_q;
    logic [7:0] ackd_q;

    // A fresh completion takes priority over the consumer's handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ackv_q <= 1'b0;
            ackd_q <= 8'h00;
        end else if (done_d) begin
            ackv_q <= 1'b1;
            ackd_q <= accept_d ? ACK_BYTE : NAK_BYTE;
        end else if (ack_ready) begin
            ackv_q <= 1'b0;
        end
    end

    assign ack_valid = ackv_q;
    assign ack_data  = ackd_q;
`else
    logic unused_done;
    assign unused_done = done_d ^ accept_d;
`endif

endmodule
